// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for a shared FIFO with bounded bursts.
// A winner keeps ownership for up to MAX_BURST words; a full FIFO stalls without ending a burst.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic                           fifo_full,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           write_enable,
  output logic [DATA_WIDTH-1:0]          din,
  output logic                           owner_valid,
  output logic [15:0]                    write_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [3:0]       burst_cnt;

  logic             cont;
  logic             rel;
  logic [PTR_W-1:0] base;
  logic [PTR_W-1:0] search_idx;
  logic [PTR_W-1:0] arb_idx;
  logic             arb_found;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_any;
  logic [3:0]       cnt_next;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // On release the old owner drops to lowest priority in the same cycle.
  always_comb begin
    cont       = (state == BURST) && req[owner];
    rel        = (state == BURST) && !req[owner];
    base       = rel ? next_idx(owner) : rr_ptr;
    arb_found  = 1'b0;
    arb_idx    = base;
    search_idx = base;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!arb_found && req[search_idx]) begin
        arb_found = 1'b1;
        arb_idx   = search_idx;
      end
      search_idx = next_idx(search_idx);
    end
    grant_idx = cont ? owner : arb_idx;
    grant_any = !reset && !fifo_full && (cont || arb_found);
    cnt_next  = burst_cnt + 4'd1;
  end

  always_comb begin
    grant = '0;
    din   = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) din = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign write_enable = grant_any;
  assign owner_valid  = !reset && (state == BURST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      burst_cnt   <= '0;
      write_count <= '0;
    end else if (!fifo_full) begin
      if (grant_any) write_count <= write_count + 16'd1;
      if (cont) begin
        burst_cnt <= cnt_next;
        if (cnt_next == 4'(MAX_BURST)) begin
          state  <= IDLE;
          rr_ptr <= next_idx(owner);
        end
      end else begin
        if (rel) rr_ptr <= base;
        if (arb_found) begin
          owner     <= arb_idx;
          burst_cnt <= 4'd1;
          if (MAX_BURST == 1) begin
            state  <= IDLE;
            rr_ptr <= next_idx(arb_idx);
          end else begin
            state <= BURST;
          end
        end else begin
          state     <= IDLE;
          burst_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus random traffic
// compared against a rotating-priority ownership model.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic          fifo_full;
  logic [N-1:0]  grant;
  logic          write_enable;
  logic [DW-1:0] din;
  logic          owner_valid;
  logic [15:0]   write_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who holds the port, how many words taken, where priority starts.
  bit    m_held;
  int    m_owner, m_words, m_ptr;
  logic [15:0] m_count;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .fifo_full(fifo_full),
    .grant(grant), .write_enable(write_enable), .din(din), .owner_valid(owner_valid),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_held = 0; m_owner = 0; m_words = 0; m_ptr = 0; m_count = 16'h0;
  endfunction

  function automatic int model_pick(input logic [N-1:0] r, input logic f);
    int start;
    if (f) return -1;
    if (m_held && r[m_owner]) return m_owner;
    start = m_held ? (m_owner + 1) % N : m_ptr;
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic void model_update(input logic [N-1:0] r, input logic f, input int w);
    if (f) return;
    if (w >= 0) m_count = m_count + 16'd1;
    if (m_held && r[m_owner]) begin
      m_words++;
      if (m_words == MB) begin
        m_held = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end else begin
      if (m_held) m_ptr = (m_owner + 1) % N;
      m_held = 0;
      if (w >= 0) begin
        m_owner = w;
        m_words = 1;
        if (MB == 1) m_ptr = (w + 1) % N;
        else m_held = 1;
      end
    end
  endfunction

  // Entered just after a falling edge with inputs already driven; leaves at the next falling edge.
  task automatic run_cycle(input bit do_chk, output int gidx);
    int e;
    logic [N-1:0] eg;
    logic [DW-1:0] ed;
    logic [N-1:0] r;
    logic f;
    #1;
    r = req; f = fifo_full;
    e = model_pick(r, f);
    eg = '0; ed = '0;
    if (e >= 0) begin
      eg[e] = 1'b1;
      ed = req_data[e*DW +: DW];
    end
    if (do_chk) begin
      check_val("grant", 32'(grant), 32'(eg));
      check_val("write_enable", 32'(write_enable), 32'(e >= 0));
      check_val("din", 32'(din), 32'(ed));
      check_val("owner_valid", 32'(owner_valid), 32'(m_held));
      check_val("write_count", 32'(write_count), 32'(m_count));
      if (e >= 0) $display("write: producer %0d data %02h count %0d", e, ed, m_count);
      else        $display("idle: req %b full %0d", r, f);
    end
    @(posedge clk);
    model_update(r, f, e);
    gidx = e;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_val("rst_grant", 32'(grant), 32'h0);
    check_val("rst_owner_valid", 32'(owner_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int g;
    int cnt;
    reset = 1'b1; req = '1; req_data = '0; fifo_full = 1'b0;
    model_reset();

    // Reset held with all producers requesting
    for (int i = 0; i < 4; i++) begin
      #5;
      check_val("reset_we", 32'(write_enable), 32'h0);
      check_val("reset_grant", 32'(grant), 32'h0);
      check_val("reset_din", 32'(din), 32'h0);
      check_val("reset_count", 32'(write_count), 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    req = '0;

    // Single producer, descending data, bursts of MB with zero-bubble regrant
    req = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      req_data[7:0] = 8'(8'hFF - k);
      #1;
      check_val("single_din", 32'(din), 32'(8'hFF - k));
      check_val("single_ov", 32'(owner_valid), 32'((k % MB) != 0));
      #(-1 + 1);
      run_cycle(1'b1, g);
    end
    check_val("single_count", 32'(write_count), 32'd16);

    // Round robin with all requesting
    do_reset();
    req = 4'b1111;
    req_data = {8'hD0, 8'hC0, 8'hB0, 8'hA0};
    for (int k = 0; k < 20; k++) begin
      #1;
      check_val("rr_grant", 32'(grant), 32'(1 << ((k / MB) % N)));
      run_cycle(1'b1, g);
    end

    // Early release: owner 2 drops after two words, producer 3 waiting
    do_reset();
    req = 4'b1100;
    req_data = {8'h33, 8'h22, 8'h11, 8'h00};
    run_cycle(1'b1, g);
    run_cycle(1'b1, g);
    req[2] = 1'b0;
    #1;
    check_val("early_grant", 32'(grant), 32'b1000);
    run_cycle(1'b1, g);
    req = 4'b1001;
    run_cycle(1'b1, g);

    // Full stall mid-burst: owner 0 resumes words 3 and 4 then rotates to 1
    do_reset();
    req = 4'b0001;
    run_cycle(1'b1, g);
    run_cycle(1'b1, g);
    req = 4'b0011;
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_val("stall_we", 32'(write_enable), 32'h0);
      run_cycle(1'b1, g);
    end
    fifo_full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val("resume_grant", 32'(grant), (k < 2) ? 32'b0001 : 32'b0010);
      run_cycle(1'b1, g);
    end

    // Asynchronous reset mid-burst, then arbitration restarts at requester 0
    req = 4'b0001;
    for (int k = 0; k < 5; k++) run_cycle(1'b1, g);
    #2;
    reset = 1'b1;
    #1;
    check_val("midrst_grant", 32'(grant), 32'h0);
    check_val("midrst_we", 32'(write_enable), 32'h0);
    check_val("midrst_ov", 32'(owner_valid), 32'h0);
    check_val("midrst_count", 32'(write_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    req = 4'b1001;
    #1;
    check_val("restart_grant", 32'(grant), 32'b0001);
    run_cycle(1'b1, g);

    // Random traffic; a producer may only change req/data right after being granted
    req = '0;
    g = -1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (i == g) begin
          req[i] = ($urandom % 4) != 0;
          req_data[i*DW +: DW] = 8'($urandom);
        end else if (!req[i]) begin
          req[i] = ($urandom % 3) == 0;
          req_data[i*DW +: DW] = 8'($urandom);
        end
      end
      fifo_full = ($urandom % 5) == 0;
      run_cycle(1'b1, g);
    end

    // Count wrap: stream single-producer writes up to 0xFFFF, then one more
    fifo_full = 1'b0;
    req = 4'b0001;
    cnt = 0;
    while (m_count != 16'hFFFF && cnt < 70000) begin
      run_cycle(1'b0, g);
      cnt++;
    end
    #1;
    check_val("count_max", 32'(write_count), 32'hFFFF);
    run_cycle(1'b0, g);
    #1;
    check_val("count_wrap", 32'(write_count), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the 8-bit `fifo` between NUM_REQ producer blocks.
- Round-robin arbitration with bounded bursts: a winner may write up to MAX_BURST consecutive words before ownership rotates.
- Drives the fifo's write_enable/din and obeys its full flag, so no producer ever writes into a full FIFO.
- Read side of the FIFO is untouched.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_WIDTH, 8, word width; matches fifo din.
- MAX_BURST, 4, maximum words per ownership period (1..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req  input  NUM_REQ  per-producer request; producer holds req and its data until granted.
- req_data  input  NUM_REQ*DATA_WIDTH  producer i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- fifo_full  input  1  full flag from fifo.
- grant  output  NUM_REQ  one-hot; grant[i]=1 means word of producer i is written this cycle.
- write_enable  output  1  to fifo; equals |grant.
- din  output  DATA_WIDTH  to fifo; req_data slice of granted producer, 0 when no grant.
- owner_valid  output  1  high while a burst owner is held (state BURST).
- write_count  output  16  total accepted words, wraps 0xFFFF->0x0000.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, write_count=0.
  - While reset=1: grant=0, write_enable=0, din=0, owner_valid=0, regardless of req.
- Handshake:
  - grant/write_enable/din are combinational from registered state + req + fifo_full.
  - A word is transferred in exactly the cycle grant[i]=1; the fifo captures it on that rising edge.
  - Producer updates data/req after that edge.
  - Zero-latency acceptance; at most one grant per cycle.
- fifo_full=1: grant=0 and write_enable=0 in every state. State, owner, burst_cnt and rr_ptr are held; a full stall does not end or count against a burst.
- State IDLE (no owner):
  - If fifo_full=0 and any req: winner = first i with req[i] searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Grant winner; owner<=winner; burst_cnt<=1.
  - If MAX_BURST=1: rr_ptr<=winner+1 mod NUM_REQ and stay IDLE; else go BURST.
  - No req: stay IDLE, outputs 0.
- State BURST (owner held, owner_valid=1):
  - Continue when req[owner]=1, fifo_full=0, burst_cnt<MAX_BURST: grant owner, burst_cnt<=burst_cnt+1. If new burst_cnt==MAX_BURST, next state is release.
  - Release when req[owner]=0 or burst_cnt==MAX_BURST:
    - rr_ptr<=owner+1 mod NUM_REQ.
    - The same cycle performs IDLE arbitration with the updated pointer (zero-bubble handover); the old owner has lowest priority.
    - If no other req and the old owner is still requesting, the old owner wins again with burst_cnt=1.
  - fifo_full=1 in BURST: hold everything.
  - req[owner] dropping during a full stall triggers release once full clears.
- write_count increments by 1 on every cycle with write_enable=1; 16-bit wraparound.
- Reset mid-burst: all outputs drop to 0 asynchronously; after release, arbitration restarts at requester 0.
- req changes on non-owner lines never preempt an active burst.
- Widths: burst_cnt 4 bits; rr_ptr/owner clog2(NUM_REQ) bits; wrap done by explicit compare to NUM_REQ-1, not bit truncation.

Test Plan:
- Reset check: assert reset 20 ns with req=4'b1111 -> grant=0, write_enable=0, din=0, write_count=0 throughout.
- Single producer:
  - Stimulus: req=4'b0001, data 0xFF..0xF0 advanced after each grant, fifo_full=0.
  - Response: 16 consecutive write_enable cycles, din sequence 0xFF..0xF0.
  - Ownership sequence: owner_valid drops each 4th word, then producer 0 is regranted without a bubble.
  - Final write_count=16.
- Round-robin:
  - Stimulus: req=4'b1111 held, data per producer 0xA0/0xB0/0xC0/0xD0, MAX_BURST=4.
  - Response: grant pattern 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again; no idle cycle between owners.
- Early release:
  - Stimulus: producer 2 owner drops req after 2 words, producer 3 requesting.
  - Response: cycle after last owner word grants producer 3; rr_ptr advanced to 3.
- Full stall:
  - Stimulus: fifo_full=1 for 5 cycles mid-burst after 2 words.
  - Response: write_enable=0 for those 5 cycles; on full=0, same owner writes words 3 and 4, then rotates.
- Count wrap: preload via 65535 accepted writes then 1 more -> write_count=0x0000.
